seq_logic_unit: RTL



---
 rtl/seq_logic_pkg.sv | 18 +
 rtl/logic_slice.sv | 30 +++
 rtl/seq_logic_unit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/seq_logic_pkg.sv
// Shared definitions for the sliced logic unit: op codes and FSM state encoding.
// Imported by the slice datapath and the top-level sequencer.
package seq_logic_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_ANDN = 3'b100;
    localparam logic [2:0] OP_ORN  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/logic_slice.sv
// Combinational bitwise operator for one SLICE-wide chunk of the operands.
// Unknown op codes produce an all-zero slice and raise the illegal flag.
module logic_slice
    import seq_logic_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  logic [2:0]       op,
    input  logic [SLICE-1:0] a_slice,
    input  logic [SLICE-1:0] b_slice,
    output logic [SLICE-1:0] y,
    output logic             illegal
);

    // Single decode shared by every slice position; the sequencer muxes operands in.
    always_comb begin
        y       = '0;
        illegal = 1'b0;
        case (op)
            OP_AND:  y = a_slice & b_slice;
            OP_OR:   y = a_slice | b_slice;
            OP_XOR:  y = a_slice ^ b_slice;
            OP_NOR:  y = ~(a_slice | b_slice);
            OP_ANDN: y = a_slice & ~b_slice;
            OP_ORN:  y = a_slice | ~b_slice;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/seq_logic_unit.sv
// Multi-cycle bitwise logic unit: operands are processed one SLICE-bit chunk per
// clock, LSB chunk first, with valid/ready handshakes on command and result sides.
module seq_logic_unit
    import seq_logic_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             err
);

    localparam int NSLICE = (SLICE > 0) ? (WIDTH / SLICE) : 1;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

    generate
        if (SLICE < 1) begin : g_bad_slice
            $error("seq_logic_unit: SLICE must be at least 1");
        end else if ((WIDTH % SLICE) != 0) begin : g_bad_width
            $error("seq_logic_unit: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    state_t                        state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [NSLICE-1:0][SLICE-1:0]  opA_q, opA_d;
    logic [NSLICE-1:0][SLICE-1:0]  opB_q, opB_d;
    logic [2:0]                    opCode_q, opCode_d;
    logic [NSLICE-1:0][SLICE-1:0]  result_q, result_d;
    logic                          zero_q, zero_d;
    logic                          err_q, err_d;

    logic [SLICE-1:0]              sliceY;
    logic                          sliceIllegal;

    logic_slice #(.SLICE(SLICE)) u_slice (
        .op      (opCode_q),
        .a_slice (opA_q[cnt_q]),
        .b_slice (opB_q[cnt_q]),
        .y       (sliceY),
        .illegal (sliceIllegal)
    );

    // Reset clears every latch so a discarded command leaves no trace.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            opA_q    <= '0;
            opB_q    <= '0;
            opCode_q <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opA_q    <= opA_d;
            opB_q    <= opB_d;
            opCode_q <= opCode_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
        end
    end

    // Sequencer; zero and err are taken from the fully assembled word on the last slice.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        opA_d     = opA_q;
        opB_d     = opB_q;
        opCode_d  = opCode_q;
        result_d  = result_q;
        zero_d    = zero_q;
        err_d     = err_q;
        cmd_ready = 1'b0;
        res_valid = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    opA_d    = a;
                    opB_d    = b;
                    opCode_d = op;
                    result_d = '0;
                    cnt_d    = '0;
                    zero_d   = 1'b0;
                    err_d    = 1'b0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                result_d[cnt_q] = sliceY;
                if (cnt_q == LAST) begin
                    zero_d  = (result_d == '0);
                    err_d   = sliceIllegal;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign result = result_q;
    assign zero   = zero_q;
    assign err    = err_q;

endmodule
